// File: rtl/prog_loader.sv
// prog_loader: writer side of the SAP-1 RAM programming port. Streams words into RAM at consecutive
// addresses, then releases the control unit by raising run. Define PROG_READBACK_EN for per-word read-back.
module prog_loader #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int WR_PULSE   = 1,
    parameter int START_ADDR = 0
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] data_out,
    output logic              nLm,
    output logic              nWE,
    output logic              nCE,
    output logic              run,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] START_PTR  = ADDR_W'(START_ADDR);
    localparam logic [3:0]        PULSE_LAST = 4'(WR_PULSE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_SET_ADDR,
        S_WRITE,
`ifdef PROG_READBACK_EN
        S_VERIFY,
`endif
        S_NEXT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [ADDR_W-1:0] addr_out_q, addr_out_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              nlm_q, nlm_d;
    logic              nwe_q, nwe_d;
    logic              nce_q, nce_d;
    logic              run_q, run_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              last_q, last_d;
    logic [3:0]        pcnt_q, pcnt_d;

`ifndef PROG_READBACK_EN
    logic unused_rd_data;
    assign unused_rd_data = ^rd_data;
`endif

    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case leaves a signal unassigned (no latches).
        state_d    = state_q;
        in_ready_d = in_ready_q;
        addr_out_d = addr_out_q;
        data_out_d = data_out_q;
        nlm_d      = nlm_q;
        nwe_d      = nwe_q;
        nce_d      = nce_q;
        run_d      = run_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        count_d    = count_q;
        ptr_d      = ptr_q;
        last_d     = last_q;
        pcnt_d     = pcnt_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_ACCEPT;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b1;
                    run_d      = 1'b0;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    count_d    = '0;
                    ptr_d      = START_PTR;
                end
            end

            S_ACCEPT: begin
                if (in_valid && in_ready_q) begin
                    data_out_d = in_data;
                    last_d     = in_last;
                    in_ready_d = 1'b0;
                    addr_out_d = ptr_q;
                    nlm_d      = 1'b0;
                    state_d    = S_SET_ADDR;
                end
            end

            S_SET_ADDR: begin
                nlm_d   = 1'b1;
                nwe_d   = 1'b0;
                pcnt_d  = '0;
                state_d = S_WRITE;
            end

            S_WRITE: begin
                if (pcnt_q == PULSE_LAST) begin
                    nwe_d = 1'b1;
`ifdef PROG_READBACK_EN
                    nce_d   = 1'b0;
                    pcnt_d  = '0;
                    state_d = S_VERIFY;
`else
                    count_d = count_q + 1'b1;
                    ptr_d   = ptr_q + 1'b1;
                    state_d = S_NEXT;
`endif
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end

`ifdef PROG_READBACK_EN
            // RAM output needs a cycle to settle after nCE falls; sample on the second cycle.
            S_VERIFY: begin
                if (pcnt_q == 4'd0) begin
                    pcnt_d = 4'd1;
                end else begin
                    nce_d = 1'b1;
                    if (rd_data != data_out_q) begin
                        err_d = 1'b1;
                    end
                    count_d = count_q + 1'b1;
                    ptr_d   = ptr_q + 1'b1;
                    state_d = S_NEXT;
                end
            end
`endif

            S_NEXT: begin
                // A pointer that has wrapped back to the start means every RAM word was used without in_last.
                if (last_q || (ptr_q == START_PTR)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    run_d   = 1'b1;
                    if (!last_q) begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d    = S_ACCEPT;
                    in_ready_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
        if (CLR) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
            addr_out_q <= START_PTR;
            data_out_q <= '0;
            nlm_q      <= 1'b1;
            nwe_q      <= 1'b1;
            nce_q      <= 1'b1;
            run_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            count_q    <= '0;
            ptr_q      <= START_PTR;
            last_q     <= 1'b0;
            pcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            addr_out_q <= addr_out_d;
            data_out_q <= data_out_d;
            nlm_q      <= nlm_d;
            nwe_q      <= nwe_d;
            nce_q      <= nce_d;
            run_q      <= run_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            count_q    <= count_d;
            ptr_q      <= ptr_d;
            last_q     <= last_d;
            pcnt_q     <= pcnt_d;
        end
    end

    assign in_ready = in_ready_q;
    assign addr_out = addr_out_q;
    assign data_out = data_out_q;
    assign nLm      = nlm_q;
    assign nWE      = nwe_q;
    assign nCE      = nce_q;
    assign run      = run_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign count    = count_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed scenarios plus randomized loads, checked against a
// bus monitor (MAR/RAM model) and expectations computed from the word list.
module tb_prog_loader;

    localparam int ADDR_W     = 4;
    localparam int DATA_W     = 8;
    localparam int WR_PULSE   = 1;
    localparam int START_ADDR = 0;
    localparam int DEPTH      = 1 << ADDR_W;
`ifdef PROG_READBACK_EN
    localparam int WORD_CYC     = 5 + WR_PULSE;
    localparam int NCE_PER_WORD = 2;
`else
    localparam int WORD_CYC     = 3 + WR_PULSE;
    localparam int NCE_PER_WORD = 0;
`endif

    logic              CLK;
    logic              CLR;
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] addr_out;
    logic [DATA_W-1:0] data_out;
    logic              nLm;
    logic              nWE;
    logic              nCE;
    logic              run;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   count;

    prog_loader #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .WR_PULSE  (WR_PULSE),
        .START_ADDR(START_ADDR)
    ) dut (
        .CLK     (CLK),
        .CLR     (CLR),
        .start   (start),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_last (in_last),
        .in_ready(in_ready),
        .rd_data (rd_data),
        .addr_out(addr_out),
        .data_out(data_out),
        .nLm     (nLm),
        .nWE     (nWE),
        .nCE     (nCE),
        .run     (run),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .count   (count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Bus monitor: rebuilds MAR and RAM from the strobes and records every write burst.
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                len;
    } wr_t;

    wr_t               wr_q[$];
    int                nlm_cyc_q[$];
    int                cyc = 0;
    int                mon_epoch = 0;
    int                seen_epoch = 0;
    int                unstable = 0;
    int                overlap = 0;
    int                rdy_drop = 0;
    int                strobe_rdy = 0;
    int                nce_low = 0;
    logic [ADDR_W-1:0] mar = '0;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              in_wr = 1'b0;
    wr_t               cur;
    logic              prev_rdy = 1'b0;
    logic              prev_val = 1'b0;
    logic              prev_clr = 1'b0;
    logic              corrupt_55 = 1'b0;

    assign rd_data = (corrupt_55 && mem[mar] == 8'h55) ? '0 : mem[mar];

    always @(negedge CLK) begin
        cyc <= cyc + 1;
        if (mon_epoch != seen_epoch) begin
            seen_epoch <= mon_epoch;
            wr_q.delete();
            nlm_cyc_q.delete();
            unstable   <= 0;
            overlap    <= 0;
            rdy_drop   <= 0;
            strobe_rdy <= 0;
            nce_low    <= 0;
            in_wr      <= 1'b0;
            prev_rdy   <= 1'b0;
            prev_val   <= 1'b0;
            prev_clr   <= 1'b0;
        end else begin
            if (!nLm) begin
                mar <= addr_out;
                nlm_cyc_q.push_back(cyc);
            end
            if (!nWE) begin
                mem[mar] <= data_out;
                if (!in_wr) begin
                    in_wr <= 1'b1;
                    cur   <= '{addr: mar, data: data_out, len: 1};
                    if (addr_out != mar) unstable <= unstable + 1;
                end else begin
                    cur.len <= cur.len + 1;
                    if (addr_out != cur.addr || data_out != cur.data) unstable <= unstable + 1;
                end
            end else if (in_wr) begin
                in_wr <= 1'b0;
                wr_q.push_back(cur);
                if (addr_out != cur.addr || data_out != cur.data) unstable <= unstable + 1;
            end
            if (!nCE) nce_low <= nce_low + 1;
            if (int'(!nLm) + int'(!nWE) + int'(!nCE) > 1) overlap <= overlap + 1;
            if (in_ready && (!nLm || !nWE || !nCE)) strobe_rdy <= strobe_rdy + 1;
            if (prev_rdy && !prev_val && !prev_clr && !in_ready) rdy_drop <= rdy_drop + 1;
            prev_rdy <= in_ready;
            prev_val <= in_valid;
            prev_clr <= CLR;
        end
    end

    // Word list for the current load; the reference expectations are derived from it.
    logic [DATA_W-1:0] tx_data[$];
    logic              tx_last[$];
    int                tx_gap[$];
    int                inject_at = -1;
    logic              exp_over = 1'b0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_load();
        tx_data.delete();
        tx_last.delete();
        tx_gap.delete();
        inject_at = -1;
        exp_over  = 1'b0;
    endtask

    task automatic push_word(input logic [DATA_W-1:0] d, input logic l, input int g);
        tx_data.push_back(d);
        tx_last.push_back(l);
        tx_gap.push_back(g);
    endtask

    task automatic gen_load(input int n, input logic over, input int max_gap);
        clear_load();
        exp_over = over;
        for (int i = 0; i < n; i++) begin
            push_word(8'($urandom), !over && (i == n - 1), $urandom_range(0, max_gap));
        end
    endtask

    task automatic begin_load(input string tag);
        mon_epoch++;
        start = 1'b1;
        tick();
        start = 1'b0;
        check($sformatf("%s/start_busy", tag), busy, 1);
        check($sformatf("%s/start_run", tag), run, 0);
        check($sformatf("%s/start_done", tag), done, 0);
        check($sformatf("%s/start_err", tag), err, 0);
        check($sformatf("%s/start_count", tag), count, 0);
        check($sformatf("%s/start_ready", tag), in_ready, 1);
    endtask

    task automatic drive_stream(input string tag);
        int t;
        for (int i = 0; i < tx_data.size(); i++) begin
            in_valid = 1'b0;
            for (int g = 0; g < tx_gap[i]; g++) tick();
            if (i == inject_at) begin
                t = 0;
                while (!in_ready && t < 100) begin
                    tick();
                    t++;
                end
                start = 1'b1;
                tick();
                start = 1'b0;
                check($sformatf("%s/ignored_start_count", tag), count, i);
                check($sformatf("%s/ignored_start_ready", tag), in_ready, 1);
                check($sformatf("%s/ignored_start_run", tag), run, 0);
            end
            in_valid = 1'b1;
            in_data  = tx_data[i];
            in_last  = tx_last[i];
            t = 0;
            while (!in_ready && t < 100) begin
                tick();
                t++;
            end
            if (!in_ready) begin
                check($sformatf("%s/ready_timeout_w%0d", tag, i), in_ready, 1);
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic finish_load(input string tag);
        int   t;
        int   n;
        logic rb_err;
        t = 0;
        while (!done && t < 400) begin
            tick();
            t++;
        end
        n = tx_data.size();
        rb_err = 1'b0;
`ifdef PROG_READBACK_EN
        for (int i = 0; i < n; i++) begin
            if (corrupt_55 && tx_data[i] == 8'h55) rb_err = 1'b1;
        end
`endif
        check($sformatf("%s/done", tag), done, 1);
        check($sformatf("%s/run", tag), run, 1);
        check($sformatf("%s/busy", tag), busy, 0);
        check($sformatf("%s/ready", tag), in_ready, 0);
        check($sformatf("%s/count", tag), count, n);
        check($sformatf("%s/err", tag), err, exp_over | rb_err);
        check($sformatf("%s/n_writes", tag), wr_q.size(), n);
        check($sformatf("%s/n_mar_loads", tag), nlm_cyc_q.size(), n);
        for (int i = 0; i < n && i < wr_q.size(); i++) begin
            check($sformatf("%s/addr_w%0d", tag, i), wr_q[i].addr, (START_ADDR + i) % DEPTH);
            check($sformatf("%s/data_w%0d", tag, i), wr_q[i].data, tx_data[i]);
            check($sformatf("%s/pulse_w%0d", tag, i), wr_q[i].len, WR_PULSE);
        end
        for (int i = 1; i < n && i < nlm_cyc_q.size(); i++) begin
            if (i != inject_at) begin
                check($sformatf("%s/spacing_w%0d", tag, i), nlm_cyc_q[i] - nlm_cyc_q[i-1],
                      (tx_gap[i] + 1 > WORD_CYC) ? tx_gap[i] + 1 : WORD_CYC);
            end
        end
        check($sformatf("%s/unstable", tag), unstable, 0);
        check($sformatf("%s/strobe_overlap", tag), overlap, 0);
        check($sformatf("%s/ready_dropped", tag), rdy_drop, 0);
        check($sformatf("%s/strobe_while_ready", tag), strobe_rdy, 0);
        check($sformatf("%s/nce_low_cycles", tag), nce_low, n * NCE_PER_WORD);
    endtask

    initial begin
        int t;
        CLR      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        repeat (3) tick();
        check("reset/run", run, 0);
        check("reset/nLm", nLm, 1);
        check("reset/nWE", nWE, 1);
        check("reset/nCE", nCE, 1);
        check("reset/in_ready", in_ready, 0);
        check("reset/busy", busy, 0);
        check("reset/done", done, 0);
        check("reset/err", err, 0);
        check("reset/count", count, 0);
        check("reset/addr_out", addr_out, START_ADDR);
        check("reset/data_out", data_out, 0);
        CLR = 1'b0;
        repeat (2) tick();

        // Three words streamed back to back.
        clear_load();
        push_word(8'h0E, 1'b0, 0);
        push_word(8'h1F, 1'b0, 0);
        push_word(8'hF0, 1'b1, 0);
        begin_load("basic");
        drive_stream("basic");
        finish_load("basic");

        // Source stalls five cycles before each word.
        clear_load();
        push_word(8'hA1, 1'b0, 5);
        push_word(8'hB2, 1'b0, 5);
        push_word(8'hC3, 1'b1, 5);
        begin_load("stall");
        drive_stream("stall");
        finish_load("stall");

        // Sixteen words without in_last: RAM fills and the load ends in error.
        gen_load(DEPTH, 1'b1, 0);
        begin_load("overrun");
        drive_stream("overrun");
        finish_load("overrun");
        in_valid = 1'b1;
        in_data  = 8'h77;
        repeat (4) tick();
        check("overrun/after_ready", in_ready, 0);
        check("overrun/after_count", count, DEPTH);
        check("overrun/after_writes", wr_q.size(), DEPTH);
        in_valid = 1'b0;

        // Restart from DONE clears err, then a start during ACCEPT is ignored.
        clear_load();
        push_word(8'h10, 1'b0, 0);
        push_word(8'h20, 1'b0, 0);
        push_word(8'h30, 1'b0, 0);
        push_word(8'h40, 1'b1, 0);
        inject_at = 2;
        begin_load("restart");
        drive_stream("restart");
        finish_load("restart");

        // CLR while nWE is low aborts the write.
        begin_load("clr");
        in_valid = 1'b1;
        in_data  = 8'hA5;
        in_last  = 1'b1;
        t = 0;
        while (nWE !== 1'b0 && t < 20) begin
            tick();
            t++;
        end
        check("clr/nwe_low_seen", nWE, 0);
        in_valid = 1'b0;
        CLR = 1'b1;
        tick();
        check("clr/nWE", nWE, 1);
        check("clr/run", run, 0);
        check("clr/busy", busy, 0);
        check("clr/count", count, 0);
        check("clr/in_ready", in_ready, 0);
        check("clr/addr_out", addr_out, START_ADDR);
        CLR = 1'b0;
        tick();
        clear_load();
        push_word(8'h3C, 1'b1, 0);
        begin_load("after_clr");
        drive_stream("after_clr");
        finish_load("after_clr");

`ifdef PROG_READBACK_EN
        // RAM returns 0x00 for the word 0x55: err is flagged but the load completes.
        corrupt_55 = 1'b1;
        clear_load();
        push_word(8'h11, 1'b0, 0);
        push_word(8'h55, 1'b0, 0);
        push_word(8'h22, 1'b1, 0);
        begin_load("readback");
        drive_stream("readback");
        finish_load("readback");
        corrupt_55 = 1'b0;
`endif

        // Randomized loads of random length, data and stall gaps.
        for (int r = 0; r < 20; r++) begin
            int   n;
            logic over;
            n    = $urandom_range(1, DEPTH);
            over = (n == DEPTH) && ($urandom_range(0, 1) == 1);
            gen_load(n, over, $urandom_range(0, 6));
            begin_load($sformatf("rand%0d", r));
            drive_stream($sformatf("rand%0d", r));
            finish_load($sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Program-mode front end for the SAP-1 core. It is the writer side of the RAM programming interface that the control unit releases while run=0.
- Accepts a stream of 8-bit words over a valid/ready handshake and writes them into the 16x8 RAM at consecutive addresses. It drives the memory-address-register load (nLm) and the RAM write strobe (nWE).
- Holds the control unit in program mode until the load completes, then asserts run.

Parameters:
- ADDR_W, 4, RAM address width; RAM depth is 2^ADDR_W words.
- DATA_W, 8, RAM word width.
- WR_PULSE, 1, number of cycles nWE is held low per write; legal range 1..8.
- START_ADDR, 0, first RAM address written after start.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- CLR  in  1  synchronous active-high reset.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE or DONE.
- in_valid  in  1  source has a word on in_data.
- in_data  in  DATA_W  word to write.
- in_last  in  1  marks the final word; qualified by in_valid.
- in_ready  out  1  loader accepts a word this cycle.
- rd_data  in  DATA_W  RAM output data; used only with PROG_READBACK_EN.
- addr_out  out  ADDR_W  address presented to the MAR input.
- data_out  out  DATA_W  data presented to the RAM data input.
- nLm  out  1  load MAR, active low.
- nWE  out  1  RAM write enable, active low.
- nCE  out  1  RAM output enable, active low; held high without PROG_READBACK_EN.
- run  out  1  0 = program mode (CU idle), 1 = run.
- busy  out  1  load in progress.
- done  out  1  last load finished.
- err  out  1  sticky error flag, cleared by start or CLR.
- count  out  ADDR_W+1  number of words written in the current load.

Behaviour:
- Reset (CLR=1 at a clock edge): state=IDLE, run=0, nLm=1, nWE=1, nCE=1, in_ready=0, busy=0, done=0, err=0, count=0, addr_out=START_ADDR, data_out=0. Reset applies from any state and aborts any write in progress; nWE returns high on the same edge.
- All outputs are registered. Control strobes are never low in the same cycle as each other.
- IDLE: start=1 → ACCEPT; busy=1, run=0, err=0, count=0, pointer=START_ADDR.
- ACCEPT: in_ready=1. On a cycle with in_valid&&in_ready:
  - capture in_data into data_out and latch in_last;
  - in_ready drops the next cycle;
  - → SET_ADDR.
  - With in_valid=0, wait indefinitely.
- SET_ADDR: addr_out=pointer, nLm=0 for exactly 1 cycle → WRITE.
- WRITE: nWE=0 for WR_PULSE cycles. addr_out and data_out stay stable for the whole pulse and one cycle after it. → NEXT, or → VERIFY when the feature is enabled.
- NEXT (1 cycle): count+=1 and pointer+=1, where the pointer wraps modulo 2^ADDR_W. Then:
  - latched last=1 → DONE;
  - otherwise, the wrapped pointer equals START_ADDR (RAM full) → DONE with err=1 (overrun: no in_last by depth words);
  - otherwise → ACCEPT.
- Throughput: one word per 3+WR_PULSE cycles with in_valid held high.
- DONE: busy=0, done=1, run=1 on entry. State is held until start or CLR.
  - start in DONE → ACCEPT; run=0 and done=0 on the next edge; count and err are cleared.
- start while busy is ignored.
- in_valid outside ACCEPT is ignored; the source must hold the word until in_ready.

Optional Feature:
- Macro: PROG_READBACK_EN.
- Defined: after WRITE, the VERIFY state drives nCE=0 for 2 cycles and compares rd_data with data_out on the second cycle. A mismatch sets err=1 but the load continues. Per-word latency becomes 5+WR_PULSE cycles.
- Undefined: there is no VERIFY state, nCE is constant 1, and rd_data is unused.

Test Plan:
- Reset then start, then 3 words 0x0E, 0x1F, 0xF0 (in_last on the third) with in_valid held high → nLm lows at addresses 0, 1, 2; nWE low 1 cycle each with the matching data; count=3; done=1; run=1. With WR_PULSE=1 each word takes 4 cycles.
- Source stalls: in_valid low 5 cycles between words → in_ready stays high, no strobes are issued, and the data is written when valid returns.
- Overrun: 16 words with no in_last, START_ADDR=0 → the 16th write goes to address 15, then DONE with err=1, count=16, and in_ready=0 afterwards.
- CLR asserted during WRITE (nWE low) → nWE=1, run=0, state IDLE and count=0 on the next edge; start then restarts at START_ADDR.
- Restart from DONE: start while run=1 → run=0, done=0, err=0 next cycle. start asserted during ACCEPT is ignored.
- PROG_READBACK_EN: bench returns rd_data=0x00 for a written 0x55 → err=1, nCE low 2 cycles, and subsequent words are still written.
